// File: rtl/interrupt_dispatch_sequencer.sv
// interrupt_dispatch_sequencer: CPU-side interrupt dispatch FSM; owns IME, the EI delay and HALT wake.
// Optional feature macro: DISPATCH_LATE_VECTOR_EN (vector and serviced bit re-sampled in PUSH_LO).
// Ports:
//   i_Clk, i_nRst            clock, asynchronous active-low reset
//   i_Enable                 M-cycle tick; state and IME advance only when high
//   i_Interrupts             pending & enabled lines from the controller
//   o_Interrupt_Handled      tells the controller to clear its lowest pending bit
//   i_Instr_Boundary         CPU is about to fetch the next opcode
//   i_EI, i_DI, i_RETI       decoded instruction pulses
//   i_Halt, o_Halt_Wake      HALT state in, wake request out
//   i_PC, i_SP               CPU registers, sampled at dispatch entry
//   o_Dispatch_Active        CPU stalls fetch/decode while high
//   o_Mem_*                  bus request, write strobe, address, write data
//   o_SP_Load/Value          new SP for the CPU
//   o_PC_Load/Value          new PC for the CPU
//   o_IME                    interrupt master enable
module interrupt_dispatch_sequencer #(
   parameter logic [15:0] VEC_BASE = 16'h0040,
   parameter int          NUM_INT  = 5
) (
   input  logic               i_Clk,
   input  logic               i_nRst,
   input  logic               i_Enable,
   input  logic [NUM_INT-1:0] i_Interrupts,
   output logic               o_Interrupt_Handled,
   input  logic               i_Instr_Boundary,
   input  logic               i_EI,
   input  logic               i_DI,
   input  logic               i_RETI,
   input  logic               i_Halt,
   output logic               o_Halt_Wake,
   input  logic [15:0]        i_PC,
   input  logic [15:0]        i_SP,
   output logic               o_Dispatch_Active,
   output logic               o_Mem_Req,
   output logic               o_Mem_Wr,
   output logic [15:0]        o_Mem_Addr,
   output logic [7:0]         o_Mem_Wdata,
   output logic               o_SP_Load,
   output logic               o_PC_Load,
   output logic [15:0]        o_SP_Value,
   output logic [15:0]        o_PC_Value,
   output logic               o_IME
);
   localparam int VW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP} state_t;
   state_t        state_q, state_d;
   logic          ime_q, ime_d, dly_q, dly_d, vld_q, vld_d;
   logic [15:0]   pc_q, pc_d, sp_q, sp_d;
   logic [VW-1:0] vec_q, vec_d, low;
   logic          any, entry;
   always_comb begin
      low = '0;
      for (int i = NUM_INT - 1; i >= 0; i--)
         if (i_Interrupts[i]) low = VW'(i);
   end
   assign any   = |i_Interrupts;
   assign entry = (state_q == IDLE) && i_Instr_Boundary && ime_q && any;
   always_comb begin
      state_d = state_q;
      ime_d   = ime_q;
      dly_d   = dly_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      vec_d   = vec_q;
      vld_d   = vld_q;
      if (i_Enable) begin
         if (entry) begin
            state_d = WAIT1;
            ime_d   = 1'b0;
            dly_d   = 1'b0;
            pc_d    = i_PC;
            sp_d    = i_SP;
            vec_d   = low;
            vld_d   = 1'b1;
         end else if (state_q == IDLE) begin
            // EI promotes at this boundary; ime_q was still 0 so entry could not fire here
            if (dly_q && i_Instr_Boundary) begin
               ime_d = 1'b1;
               dly_d = 1'b0;
            end
            if (i_RETI) ime_d = 1'b1;
            if (i_EI) dly_d = 1'b1;
            if (i_DI) begin
               ime_d = 1'b0;
               dly_d = 1'b0;
            end
         end else begin
            state_d = (state_q == JUMP) ? IDLE : state_t'(state_q + 3'd1);
`ifdef DISPATCH_LATE_VECTOR_EN
            // the PUSH_HI write may have changed IE, so the vector is decided here
            if (state_q == PUSH_LO) begin
               vec_d = low;
               vld_d = any;
            end
`endif
         end
      end
   end
   always_ff @(posedge i_Clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state_q <= IDLE;
         ime_q   <= 1'b0;
         dly_q   <= 1'b0;
         pc_q    <= '0;
         sp_q    <= '0;
         vec_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ime_q   <= ime_d;
         dly_q   <= dly_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         vec_q   <= vec_d;
         vld_q   <= vld_d;
      end
   end
   assign o_IME             = ime_q;
   assign o_Halt_Wake       = i_Halt & any;
   assign o_Dispatch_Active = state_q != IDLE;
   assign o_Mem_Req         = (state_q == PUSH_HI) || (state_q == PUSH_LO);
   assign o_Mem_Wr          = o_Mem_Req;
   assign o_Mem_Addr        = (state_q == PUSH_HI) ? sp_q - 16'd1 :
                              (state_q == PUSH_LO) ? sp_q - 16'd2 : '0;
   assign o_Mem_Wdata       = (state_q == PUSH_HI) ? pc_q[15:8] :
                              (state_q == PUSH_LO) ? pc_q[7:0] : '0;
   assign o_SP_Load         = state_q == JUMP;
   assign o_PC_Load         = state_q == JUMP;
   assign o_SP_Value        = (state_q == JUMP) ? sp_q - 16'd2 : '0;
   assign o_PC_Value        = (state_q == JUMP && vld_q) ? VEC_BASE + 16'({vec_q, 3'b000}) : '0;
`ifdef DISPATCH_LATE_VECTOR_EN
   assign o_Interrupt_Handled = (state_q == PUSH_LO) && i_Enable && any;
`else
   assign o_Interrupt_Handled = (state_q == PUSH_LO) && i_Enable;
`endif
endmodule
